// File: rtl/dsp_pipe_ctrl.sv
// Pipeline controller for the DSP48A1 datapath: per-stage CE/sel/srst generation,
// valid tracking through the registered stages, handshakes, stalls and flush.
module dsp_pipe_ctrl #(
    parameter int                NSTG   = 5,
    parameter logic [NSTG-1:0]   REG_EN = 5'b11111
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    output logic                            out_valid,
    input  logic                            out_ready,
    input  logic                            flush,
    output logic [NSTG-1:0]                 ce,
    output logic [NSTG-1:0]                 sel,
    output logic                            srst,
    output logic [$clog2(NSTG+1)-1:0]       occupancy,
    output logic                            busy
);

    function automatic int popcnt(input logic [NSTG-1:0] m);
        int c;
        c = 0;
        for (int i = 0; i < NSTG; i++) c += int'(m[i]);
        return c;
    endfunction

    localparam int L  = popcnt(REG_EN);
    localparam int LV = (L > 0) ? L : 1;
    localparam int OW = $clog2(NSTG+1);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_FLUSH = 2'd1;
    localparam logic [1:0] ST_CLEAR = 2'd2;

    logic [1:0]    state_q, state_d;
    logic          srst_q, srst_d;
    logic [LV-1:0] v_q, v_d;
    logic          advance;
    logic          run;

    assign run  = (state_q == ST_RUN);
    assign busy = ~run;
    assign srst = srst_q;
    assign sel  = REG_EN;

    genvar gi;
    generate
        for (gi = 0; gi < NSTG; gi++) begin : g_ce
            assign ce[gi] = advance & REG_EN[gi];
        end

        if (L > 0) begin : g_track
            logic accept;
            assign out_valid = v_q[LV-1];
            assign advance   = ~out_valid | out_ready;
            assign in_ready  = advance & run;
            assign accept    = in_valid & in_ready;

            // One valid bit per registered stage; the whole chain moves together.
            always_comb begin
                v_d = v_q;
                if (advance) begin
                    for (int i = LV-1; i > 0; i--) v_d[i] = v_q[i-1];
                    v_d[0] = accept;
                end
            end

            always_comb begin
                occupancy = '0;
                for (int i = 0; i < LV; i++) occupancy = occupancy + OW'(v_q[i]);
            end
        end else begin : g_comb
            // Fully bypassed datapath: output is combinational from the input.
            assign out_valid = in_valid & run;
            assign advance   = ~out_valid | out_ready;
            assign in_ready  = out_ready & run;
            assign occupancy = '0;
            always_comb v_d = '0;
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:   if (flush)       state_d = ST_FLUSH;
            ST_FLUSH: if (v_q == '0)   state_d = ST_CLEAR;
            ST_CLEAR:                  state_d = ST_RUN;
            default:                   state_d = ST_RUN;
        endcase
        srst_d = (state_d == ST_CLEAR);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
            srst_q  <= 1'b0;
            v_q     <= '0;
        end else begin
            state_q <= state_d;
            srst_q  <= srst_d;
            v_q     <= v_d;
        end
    end

endmodule

// File: tb/tb_dsp_pipe_ctrl.sv
// Bench for dsp_pipe_ctrl: three configurations run in lockstep against a
// queue-of-item-ages reference model.
module tb_dsp_pipe_ctrl;

    logic        clk = 1'b0;
    logic        clk_run = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic        flush = 1'b0;
    logic [2:0]  ir_w, ov_w, srst_w, busy_w;
    logic [14:0] ce_all, sel_all;
    logic [8:0]  occ_all;

    int n_checks = 0;
    int n_pass   = 0;

    int         lk[3]  = '{5, 2, 0};
    logic [4:0] rek[3] = '{5'b11111, 5'b00101, 5'b00000};
    int         age[3][8];
    int         cnt[3];
    int         mst[3];

    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    dsp_pipe_ctrl #(.NSTG(5), .REG_EN(5'b11111)) u0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_w[0]),
        .out_valid(ov_w[0]), .out_ready(out_ready), .flush(flush),
        .ce(ce_all[4:0]), .sel(sel_all[4:0]), .srst(srst_w[0]),
        .occupancy(occ_all[2:0]), .busy(busy_w[0]));

    dsp_pipe_ctrl #(.NSTG(5), .REG_EN(5'b00101)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_w[1]),
        .out_valid(ov_w[1]), .out_ready(out_ready), .flush(flush),
        .ce(ce_all[9:5]), .sel(sel_all[9:5]), .srst(srst_w[1]),
        .occupancy(occ_all[5:3]), .busy(busy_w[1]));

    dsp_pipe_ctrl #(.NSTG(5), .REG_EN(5'b00000)) u2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_w[2]),
        .out_valid(ov_w[2]), .out_ready(out_ready), .flush(flush),
        .ce(ce_all[14:10]), .sel(sel_all[14:10]), .srst(srst_w[2]),
        .occupancy(occ_all[8:6]), .busy(busy_w[2]));

    // Reference model: each in-flight item carries the number of pipeline moves
    // it has made; an item at age L is presented at the output.
    function automatic bit m_run(int k);
        return mst[k] == 0;
    endfunction

    function automatic bit m_ov(int k);
        if (lk[k] == 0) return in_valid && m_run(k);
        return (cnt[k] > 0) && (age[k][0] == lk[k]);
    endfunction

    function automatic bit m_adv(int k);
        return !m_ov(k) || out_ready;
    endfunction

    function automatic bit m_ir(int k);
        if (lk[k] == 0) return out_ready && m_run(k);
        return m_adv(k) && m_run(k);
    endfunction

    function automatic logic [4:0] m_ce(int k);
        return m_adv(k) ? rek[k] : 5'b00000;
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 3; k++) begin
            cnt[k] = 0;
            mst[k] = 0;
        end
    endfunction

    function automatic void model_step(int k);
        bit ov, adv, acc, empty;
        ov    = m_ov(k);
        adv   = m_adv(k);
        acc   = in_valid && m_ir(k);
        empty = (cnt[k] == 0);
        if (lk[k] > 0 && adv) begin
            if (ov) begin
                for (int i = 0; i < cnt[k]-1; i++) age[k][i] = age[k][i+1];
                cnt[k]--;
            end
            for (int i = 0; i < cnt[k]; i++) age[k][i]++;
            if (acc) begin
                age[k][cnt[k]] = 1;
                cnt[k]++;
            end
        end
        case (mst[k])
            0: if (flush) mst[k] = 1;
            1: if (empty) mst[k] = 2;
            default: mst[k] = 0;
        endcase
    endfunction

    task automatic drive(bit iv, bit ordy, bit fl);
        in_valid  = iv;
        out_ready = ordy;
        flush     = fl;
        #1;
    endtask

    task automatic advance_clk();
        @(posedge clk);
        for (int k = 0; k < 3; k++) model_step(k);
        @(negedge clk);
    endtask

    task automatic test_reset();
        out_ready = 1'b1;
        rst = 1'b1;
        #2;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (ov_w[k] !== 1'b0 || occ_all[k*3 +: 3] !== 3'd0 || srst_w[k] !== 1'b0 ||
                busy_w[k] !== 1'b0 || ir_w[k] !== 1'b1)
                $display("FAIL reset_outs[%0d] got ov=%b occ=%0d srst=%b busy=%b ir=%b exp 0 0 0 0 1",
                         k, ov_w[k], occ_all[k*3 +: 3], srst_w[k], busy_w[k], ir_w[k]);
            else n_pass++;
            n_checks++;
            if (ce_all[k*5 +: 5] !== rek[k] || sel_all[k*5 +: 5] !== rek[k])
                $display("FAIL reset_ce_sel[%0d] got ce=%b sel=%b exp %b", k,
                         ce_all[k*5 +: 5], sel_all[k*5 +: 5], rek[k]);
            else n_pass++;
        end
        rst = 1'b0;
        #2;
        clk_run = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_stream();
        int first, nvalid, last;
        first = -1; nvalid = 0; last = -1;
        for (int c = 0; c < 18; c++) begin
            drive(c < 8, 1'b1, 1'b0);
            n_checks++;
            if (ov_w[0] !== m_ov(0) || occ_all[2:0] !== 3'(cnt[0]))
                $display("FAIL stream c=%0d got ov=%b occ=%0d exp ov=%b occ=%0d",
                         c, ov_w[0], occ_all[2:0], m_ov(0), cnt[0]);
            else n_pass++;
            if (c == 6) begin
                n_checks++;
                if (occ_all[2:0] !== 3'd5) $display("FAIL stream_occ_mid got %0d exp 5", occ_all[2:0]);
                else n_pass++;
            end
            if (ov_w[0] === 1'b1) begin
                if (first < 0) first = c;
                nvalid++;
                last = c;
            end
            advance_clk();
        end
        n_checks++;
        if (first != 5 || nvalid != 8 || last != 12)
            $display("FAIL stream_timing got first=%0d count=%0d last=%0d exp 5 8 12", first, nvalid, last);
        else n_pass++;
    endtask

    task automatic test_stall();
        int nout;
        nout = 0;
        for (int c = 0; c < 5; c++) begin
            drive(1'b1, 1'b1, 1'b0);
            advance_clk();
        end
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 1'b0, 1'b0);
            n_checks++;
            if (ce_all[4:0] !== 5'b0 || ir_w[0] !== 1'b0 || occ_all[2:0] !== 3'd5 || ov_w[0] !== 1'b1)
                $display("FAIL stall c=%0d got ce=%b ir=%b occ=%0d ov=%b exp 00000 0 5 1",
                         c, ce_all[4:0], ir_w[0], occ_all[2:0], ov_w[0]);
            else n_pass++;
            advance_clk();
        end
        for (int c = 0; c < 10; c++) begin
            drive(1'b0, 1'b1, 1'b0);
            n_checks++;
            if (ov_w[0] !== m_ov(0)) $display("FAIL stall_drain c=%0d got ov=%b exp %b", c, ov_w[0], m_ov(0));
            else n_pass++;
            if (ov_w[0] === 1'b1) nout++;
            advance_clk();
        end
        n_checks++;
        if (nout != 5) $display("FAIL stall_count got %0d outputs exp 5", nout);
        else n_pass++;
    endtask

    task automatic test_flush();
        int nsrst, nout;
        nsrst = 0; nout = 0;
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 1'b1, 1'b0);
            advance_clk();
        end
        drive(1'b0, 1'b1, 1'b1);
        advance_clk();
        for (int c = 0; c < 14; c++) begin
            drive(1'b0, 1'b1, c == 1);
            for (int k = 0; k < 3; k++) begin
                n_checks++;
                if (ir_w[k] !== m_ir(k) || busy_w[k] !== !m_run(k) || srst_w[k] !== (mst[k] == 2) ||
                    ov_w[k] !== m_ov(k))
                    $display("FAIL flush[%0d] c=%0d got ir=%b busy=%b srst=%b ov=%b exp %b %b %b %b",
                             k, c, ir_w[k], busy_w[k], srst_w[k], ov_w[k],
                             m_ir(k), !m_run(k), mst[k] == 2, m_ov(k));
                else n_pass++;
            end
            if (busy_w[0] === 1'b1) begin
                n_checks++;
                if (ir_w[0] !== 1'b0) $display("FAIL flush_ir c=%0d got %b exp 0", c, ir_w[0]);
                else n_pass++;
                if (ov_w[0] === 1'b1) nout++;
            end
            if (srst_w[0] === 1'b1) nsrst++;
            advance_clk();
        end
        n_checks++;
        if (nsrst != 1 || nout != 3 || busy_w[0] !== 1'b0 || ir_w[0] !== 1'b1)
            $display("FAIL flush_summary got srst_cycles=%0d outs=%0d busy=%b ir=%b exp 1 3 0 1",
                     nsrst, nout, busy_w[0], ir_w[0]);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            drive(($urandom % 4) != 0, ($urandom % 4) != 0, ($urandom % 16) == 0);
            for (int k = 0; k < 3; k++) begin
                n_checks++;
                if (ov_w[k] !== m_ov(k) || ir_w[k] !== m_ir(k) || occ_all[k*3 +: 3] !== 3'(cnt[k]) ||
                    ce_all[k*5 +: 5] !== m_ce(k) || busy_w[k] !== !m_run(k) || srst_w[k] !== (mst[k] == 2))
                    $display("FAIL random[%0d] c=%0d got ov=%b ir=%b occ=%0d ce=%b busy=%b srst=%b exp %b %b %0d %b %b %b",
                             k, c, ov_w[k], ir_w[k], occ_all[k*3 +: 3], ce_all[k*5 +: 5], busy_w[k], srst_w[k],
                             m_ov(k), m_ir(k), cnt[k], m_ce(k), !m_run(k), mst[k] == 2);
                else n_pass++;
            end
            n_checks++;
            if ((ce_all[9:5] & 5'b11010) !== 5'b0 || sel_all[9:5] !== 5'b00101)
                $display("FAIL cfg_00101 c=%0d got ce=%b sel=%b exp ce[4,3,1]=0 sel=00101", c, ce_all[9:5], sel_all[9:5]);
            else n_pass++;
            n_checks++;
            if (ov_w[2] !== (in_valid && m_run(2)))
                $display("FAIL cfg_00000 c=%0d got ov=%b exp %b", c, ov_w[2], in_valid && m_run(2));
            else n_pass++;
            advance_clk();
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        lat = -1;
        for (int c = 0; c < 14; c++) begin
            drive(1'b0, 1'b1, 1'b0);
            advance_clk();
        end
        for (int c = 0; c < 4; c++) begin
            drive(1'b1, 1'b1, 1'b0);
            advance_clk();
        end
        drive(1'b0, 1'b1, 1'b0);
        n_checks++;
        if (occ_all[2:0] !== 3'd4) $display("FAIL rstmid_pre got occ=%0d exp 4", occ_all[2:0]);
        else n_pass++;
        #2 rst = 1'b1;
        #1;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (ov_w[k] !== 1'b0 || occ_all[k*3 +: 3] !== 3'd0)
                $display("FAIL rstmid[%0d] got ov=%b occ=%0d exp 0 0", k, ov_w[k], occ_all[k*3 +: 3]);
            else n_pass++;
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 1'b1, 1'b0);
        advance_clk();
        for (int c = 1; c <= 10; c++) begin
            drive(1'b0, 1'b1, 1'b0);
            n_checks++;
            if (ov_w[0] !== m_ov(0) || ov_w[1] !== m_ov(1))
                $display("FAIL rstmid_after c=%0d got ov0=%b ov1=%b exp %b %b", c, ov_w[0], ov_w[1], m_ov(0), m_ov(1));
            else n_pass++;
            if (ov_w[0] === 1'b1 && lat < 0) lat = c;
            advance_clk();
        end
        n_checks++;
        if (lat != 5) $display("FAIL rstmid_latency got %0d exp 5", lat);
        else n_pass++;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_stream();
        test_stall();
        test_flush();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
